// File: rtl/dmem_slow_model.sv
// Fixed-latency word-addressed data memory model with a single-cycle write
// commit strobe for the end-of-simulation result checker.
module dmem_slow_model #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [29:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_ready,
    output logic        o_commit_wen,
    output logic [29:0] o_commit_addr,
    output logic [31:0] o_commit_data,
    output logic [15:0] o_write_count,
    output logic [1:0]  o_err_flags
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_is_wr;
    logic [29:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  r_commit_wen;
    logic [29:0]           r_commit_addr;
    logic [31:0]           r_commit_data;
    logic [15:0]           r_write_count;
    logic [1:0]            r_err;

    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_in_range = (r_addr >> DEPTH_LOG2) == 30'd0;
    assign w_idx      = r_addr[DEPTH_LOG2-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_is_wr       <= 1'b0;
            r_addr        <= 30'd0;
            r_wdata       <= 32'd0;
            r_rdata       <= 32'd0;
            r_ready       <= 1'b0;
            r_commit_wen  <= 1'b0;
            r_commit_addr <= 30'd0;
            r_commit_data <= 32'd0;
            r_write_count <= 16'd0;
            r_err         <= 2'b00;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else begin
            r_ready      <= 1'b0;
            r_commit_wen <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_mem_read || i_mem_write) begin
                        // A simultaneous read+write is resolved as a write.
                        r_is_wr <= i_mem_write;
                        r_addr  <= i_mem_addr;
                        r_wdata <= i_mem_wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                        if (i_mem_read && i_mem_write) r_err[1] <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                        if (!w_in_range) begin
                            r_err[0] <= 1'b1;
                            if (!r_is_wr) r_rdata <= 32'd0;
                        end else if (r_is_wr) begin
                            r_mem[w_idx]  <= r_wdata;
                            r_commit_addr <= r_addr;
                            r_commit_data <= r_wdata;
                            r_commit_wen  <= 1'b1;
                            if (r_write_count != 16'hFFFF)
                                r_write_count <= r_write_count + 16'd1;
                        end else begin
                            r_rdata <= r_mem[w_idx];
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_rdata   = r_rdata;
    assign o_mem_ready   = r_ready;
    assign o_commit_wen  = r_commit_wen;
    assign o_commit_addr = r_commit_addr;
    assign o_commit_data = r_commit_data;
    assign o_write_count = r_write_count;
    assign o_err_flags   = r_err;
endmodule

// File: tb/tb_dmem_slow_model.sv
// Bench for dmem_slow_model: directed table, multi-cycle corner sequences and
// random transactions scored against a transaction-level memory model.
module tb_dmem_slow_model;
    localparam int LAT   = 4;
    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready, cwen;
    logic [29:0] caddr;
    logic [31:0] cdata;
    logic [15:0] wcount;
    logic [1:0]  err;

    dmem_slow_model #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
        .i_clk(clk), .i_rst(rst), .i_mem_read(rd), .i_mem_write(wr),
        .i_mem_addr(addr), .i_mem_wdata(wdata),
        .o_mem_rdata(rdata), .o_mem_ready(ready), .o_commit_wen(cwen),
        .o_commit_addr(caddr), .o_commit_data(cdata),
        .o_write_count(wcount), .o_err_flags(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: what the memory and its outputs must look like.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata;
    logic [29:0] m_caddr;
    logic [31:0] m_cdata;
    logic [15:0] m_wc;
    logic [1:0]  m_err;
    int          exp_pulses = 0;
    int          pulses = 0;
    logic        prev_wen = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_rdata = 0; m_caddr = 0; m_cdata = 0; m_wc = 0; m_err = 0;
    endtask

    task automatic model_apply(input logic r, input logic w, input logic [29:0] a,
                               input logic [31:0] d, output logic exp_wen);
        exp_wen = 1'b0;
        if (r && w) m_err[1] = 1'b1;
        if (a >= DEPTH) begin
            m_err[0] = 1'b1;
            if (!w) m_rdata = 32'd0;
        end else if (w) begin
            m_mem[a] = d; m_caddr = a; m_cdata = d;
            if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
            exp_pulses++;
            exp_wen = 1'b1;
        end else begin
            m_rdata = m_mem[a];
        end
    endtask

    // One transaction, request held until mem_ready (a stalled requester).
    task automatic txn(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
        int  k;
        logic ew;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < LAT + 12);
        chk("ready_latency", 64'(k), 64'(LAT + 1));
        rd = 0; wr = 0;
        model_apply(r, w, a, d, ew);
        chk("rdata", rdata, m_rdata);
        chk("commit_wen", cwen, ew);
        chk("commit_addr", caddr, m_caddr);
        chk("commit_data", cdata, m_cdata);
        chk("write_count", wcount, m_wc);
        chk("err_flags", err, m_err);
    endtask

    always @(negedge clk) begin
        if (cwen) begin
            pulses++;
            chk("wen_with_ready", ready, 1'b1);
            chk("wen_single_cycle", prev_wen, 1'b0);
        end
        prev_wen = cwen;
    end

    typedef struct {
        logic rd, wr; logic [29:0] addr; logic [31:0] data;
        logic [31:0] e_rdata; logic e_wen; logic [29:0] e_caddr;
        logic [31:0] e_cdata; logic [15:0] e_wc; logic [1:0] e_err;
    } vec_t;
    vec_t vt [9];

    initial begin
        int base, n, k;
        logic ew;
        vt[0] = '{0, 1, 30'd0,   32'd5,          32'd0,          1, 30'd0, 32'd5,          16'd1, 2'b00};
        vt[1] = '{0, 1, 30'd3,   32'hDEADBEEF,   32'd0,          1, 30'd3, 32'hDEADBEEF,   16'd2, 2'b00};
        vt[2] = '{1, 0, 30'd3,   32'd0,          32'hDEADBEEF,   0, 30'd3, 32'hDEADBEEF,   16'd2, 2'b00};
        vt[3] = '{1, 0, 30'd7,   32'd0,          32'd0,          0, 30'd3, 32'hDEADBEEF,   16'd2, 2'b00};
        vt[4] = '{0, 1, 30'd256, 32'h11,         32'd0,          0, 30'd3, 32'hDEADBEEF,   16'd2, 2'b01};
        vt[5] = '{1, 0, 30'd3,   32'd0,          32'hDEADBEEF,   0, 30'd3, 32'hDEADBEEF,   16'd2, 2'b01};
        vt[6] = '{1, 0, 30'd300, 32'd0,          32'd0,          0, 30'd3, 32'hDEADBEEF,   16'd2, 2'b01};
        vt[7] = '{1, 1, 30'd2,   32'd9,          32'd0,          1, 30'd2, 32'd9,          16'd3, 2'b11};
        vt[8] = '{1, 0, 30'd2,   32'd0,          32'd9,          0, 30'd2, 32'd9,          16'd3, 2'b11};

        rst = 1; rd = 0; wr = 0; addr = 0; wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ready", ready, 0);
        chk("rst_wen", cwen, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_caddr", caddr, 0);
        chk("rst_cdata", cdata, 0);
        chk("rst_wcount", wcount, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 9; i++) begin
            txn(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data);
            chk("tbl_rdata", rdata, vt[i].e_rdata);
            chk("tbl_wen", cwen, vt[i].e_wen);
            chk("tbl_caddr", caddr, vt[i].e_caddr);
            chk("tbl_cdata", cdata, vt[i].e_cdata);
            chk("tbl_wcount", wcount, vt[i].e_wc);
            chk("tbl_err", err, vt[i].e_err);
        end

        // Stalled write: request held until ready must commit exactly once.
        base = pulses;
        txn(0, 1, 30'd1, 32'd4);
        repeat (2) @(negedge clk);
        chk("stall_pulses", 64'(pulses - base), 1);

        // 12 edges of held request: a new write starts every LAT+2 edges.
        base = pulses;
        n = 0;
        for (int t = 0; t <= 11; t += LAT + 2) n++;
        @(negedge clk);
        wr = 1; addr = 30'd1; wdata = 32'd4;
        repeat (12) @(negedge clk);
        wr = 0;
        repeat (2 * LAT + 6) @(negedge clk);
        for (int i = 0; i < n; i++) model_apply(0, 1, 30'd1, 32'd4, ew);
        chk("hold12_pulses", 64'(pulses - base), 64'(n));
        chk("hold12_wcount", wcount, m_wc);
        chk("hold12_ready_idle", ready, 0);

        // Reset during BUSY of a write discards it completely.
        @(negedge clk);
        wr = 1; addr = 30'd0; wdata = 32'h77;
        @(negedge clk);
        rst = 1; wr = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        base = pulses;
        k = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            if (ready) k++;
        end
        chk("midrst_no_ready", 64'(k), 0);
        chk("midrst_no_pulse", 64'(pulses - base), 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_caddr", caddr, 0);
        chk("midrst_cdata", cdata, 0);
        chk("midrst_wcount", wcount, 0);
        chk("midrst_err", err, 0);
        txn(1, 0, 30'd0, 32'd0);
        txn(1, 0, 30'd3, 32'd0);

        for (int i = 0; i < 150; i++) begin
            int sel;
            logic r, w;
            logic [29:0] a;
            sel = $urandom_range(0, 9);
            r = (sel == 0) || (sel > 4);
            w = (sel <= 4);
            a = ($urandom_range(0, 9) == 0) ? 30'($urandom_range(256, 1023))
                                            : 30'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(r, w, a, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("total_pulses", 64'(pulses), 64'(exp_pulses));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
